// File: rtl/pc_next_stage_if.sv
// Request/status bundle between the sequencer and the PC next-address stage.
// The master drives requests; the slave (pc_next_stage) drives address and status.
interface pc_next_stage_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              clear;
    logic              count_en;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic              call;
    logic              ret;
    logic              out_en;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bus_out;
    logic              bus_valid;
    logic              wrap;
    logic              halted;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output clear, count_en, jump, jump_addr, halt, call, ret, out_en,
        input  pc, bus_out, bus_valid, wrap, halted, stack_overflow, stack_underflow
    );

    modport slave (
        input  clear, count_en, jump, jump_addr, halt, call, ret, out_en,
        output pc, bus_out, bus_valid, wrap, halted, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/pc_next_stage.sv
// Program-counter next-address stage: increment, jump, clear, sticky halt and bus drive.
// Optional return-address stack for call/ret is built only when PC_CALL_STACK_EN is defined.
module pc_next_stage #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic            clk,
    input logic            async_reset_n,
    pc_next_stage_if.slave ctl
);
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_ADDR);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic              halted;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              wrap_q, wrap_d;
    logic              advance;

    // Stack handshake into the common next-pc logic
    logic              do_ret;
    logic              do_call;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pop_addr;

    assign pc_inc  = pc_q + 1'b1;
    // Only a running, non-clearing, non-halting cycle may act on ret/call/jump/count
    assign advance = !ctl.clear && (state_q == StRun) && !ctl.halt;

    // ------------------------------------------------------------------
    // Halt FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (!ctl.clear && ctl.halt) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (ctl.clear) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        halted = (state_q == StHalted);
    end

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
`ifdef PC_CALL_STACK_EN
    localparam int unsigned SpW    = $clog2(STACK_DEPTH);
    localparam logic [SpW:0] SpFull = (SpW + 1)'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SpW:0]      sp_q, sp_d;
    logic [SpW:0]      sp_dec;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    assign stack_full  = (sp_q == SpFull);
    assign stack_empty = (sp_q == '0);
    assign sp_dec      = sp_q - 1'b1;

    // ret outranks call when both are requested
    assign do_ret   = advance && ctl.ret;
    assign do_call  = advance && ctl.call && !ctl.ret;
    assign push     = do_call && !stack_full;
    assign pop      = do_ret && !stack_empty;
    assign pop_addr = stack_mem[sp_dec[SpW-1:0]];

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ctl.clear) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (push) begin
                sp_d = sp_q + 1'b1;
            end else if (pop) begin
                sp_d = sp_dec;
            end
            if (do_call && stack_full) begin
                ovf_d = 1'b1;
            end
            if (do_ret && stack_empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entries are never reset; an empty pointer makes stale contents unreachable
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp_q[SpW-1:0]] <= pc_inc;
        end
    end

    assign ctl.stack_overflow  = ovf_q;
    assign ctl.stack_underflow = unf_q;
`else
    localparam int unsigned unused_stack_depth = STACK_DEPTH;
    logic unused_stack_req;

    assign unused_stack_req    = ctl.call ^ ctl.ret;
    assign do_ret              = 1'b0;
    assign do_call             = 1'b0;
    assign push                = 1'b0;
    assign pop                 = 1'b0;
    assign pop_addr            = '0;
    assign ctl.stack_overflow  = 1'b0;
    assign ctl.stack_underflow = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (ctl.clear) begin
            pc_d = ResetPc;
        end else if (advance) begin
            if (do_ret) begin
                if (pop) begin
                    pc_d = pop_addr;
                end
            end else if (do_call) begin
                if (push) begin
                    pc_d = ctl.jump_addr;
                end
            end else if (ctl.jump) begin
                pc_d = ctl.jump_addr;
            end else if (ctl.count_en) begin
                pc_d   = pc_inc;
                wrap_d = (pc_q == '1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            pc_q   <= ResetPc;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign ctl.pc        = pc_q;
    assign ctl.wrap      = wrap_q;
    assign ctl.halted    = halted;
    assign ctl.bus_out   = ctl.out_en ? pc_q : '0;
    assign ctl.bus_valid = ctl.out_en;

endmodule
